instr_ctrl_fsm: RTL and testbench
=================================

INSTR_CTRL_FSM -- requirements
Module: instr_ctrl_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 7 bits: instruction opcode from the decoder.
REQ-004 SHALL have port funct3, input, 3 bits: decoder funct3.
REQ-005 SHALL have port funct7, input, 7 bits: decoder funct7.
REQ-006 SHALL have port ZF, input, 1 bit: ALU zero flag, registered outside this block.
REQ-007 SHALL have ports PC_Write and IR_Write, output, 1 bit each: the PC and IR load enables consumed by decoder_top.
REQ-008 SHALL have ports PC0_Write, Reg_Write and Mem_Write, output, 1 bit each: old-PC latch, register-file write and data-memory write enables.
REQ-009 SHALL have port rs2_imm_s, output, 1 bit: ALU B select, 0=rs2 data, 1=imm32.
REQ-010 SHALL have port w_data_s, output, 2 bits: write-back select, 00=ALU result, 01=imm32, 10=memory data, 11=PC.
REQ-011 SHALL have port PC_s, output, 2 bits: next-PC select, 00=PC+4, 01=PC0+imm32, 10=rs1+imm32.
REQ-012 SHALL have port ALU_OP, output, 4 bits: ALU operation code.
REQ-013 SHALL have port state_dbg, output, 4 bits: current state encoding.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE=0, FETCH=1, DECODE=2, EXE_R=3, EXE_I=4, WB=5, LUI=6, MEM_ADDR=7, LOAD=8, LOAD_WB=9, STORE=10, BEQ=11, JAL=12 and ERR=15; all outputs are functions of state and the decoder inputs only.
REQ-015 SHALL transition IDLE->FETCH->DECODE unconditionally, one cycle each.
REQ-016 SHALL assert IR_Write=1, PC_Write=1, PC0_Write=1 and PC_s=00 in FETCH only.
REQ-017 SHALL branch from DECODE by opcode as follows:
  - 0110011 goes to EXE_R.
  - 0010011 goes to EXE_I.
  - 0110111 goes to LUI.
  - 0000011 and 0100011 go to MEM_ADDR.
  - 1100011 with funct3=000 goes to BEQ.
  - 1101111 goes to JAL.
  - Any other opcode is illegal (see REQ-026).
REQ-018 SHALL in EXE_R drive ALU_OP={funct7[5],funct3} and rs2_imm_s=0, then go to WB.
REQ-019 SHALL in EXE_I drive rs2_imm_s=1 and ALU_OP={funct7[5]&(funct3==101),funct3}, then go to WB.
REQ-020 SHALL in WB drive Reg_Write=1 and w_data_s=00, then go to FETCH.
REQ-021 SHALL in LUI drive Reg_Write=1 and w_data_s=01, then go to FETCH.
REQ-022 SHALL in MEM_ADDR drive ALU_OP=0000 and rs2_imm_s=1, then go to LOAD if opcode=0000011, else to STORE.
REQ-023 SHALL sequence loads as LOAD (no writes) -> LOAD_WB (Reg_Write=1, w_data_s=10) -> FETCH, and stores as STORE (Mem_Write=1) -> FETCH.
REQ-024 SHALL in BEQ drive ALU_OP=1000 and rs2_imm_s=0, assert PC_Write=1 with PC_s=01 only when ZF=1, then go to FETCH.
REQ-025 SHALL in JAL drive Reg_Write=1, w_data_s=11, PC_Write=1 and PC_s=01, then go to FETCH.
REQ-026 SHALL handle illegal opcodes per REQ-031 and REQ-032.
REQ-027 SHALL drive all enables to 0 and all selects/ALU_OP to 0 in any state not listed for them; no two of Reg_Write, Mem_Write and IR_Write SHALL ever be asserted in the same cycle.
REQ-028 SHALL give per-instruction latencies, FETCH to FETCH, of R/I=4, LUI=3, LW=5, SW=4, BEQ=3 and JAL=3 cycles.

Reset
REQ-029 SHALL on rst_n=0 immediately force state=IDLE and all outputs to 0, including mid-instruction; no partial write SHALL complete after reset assertion.
REQ-030 SHALL leave IDLE on the first rising clk edge after rst_n deasserts.

Configuration
REQ-031 SHALL, when macro CTRL_ILLEGAL_TRAP_EN is defined, enter ERR from DECODE on an illegal opcode, hold ERR with all outputs 0 and state_dbg=1111 until reset.
REQ-032 SHALL, when CTRL_ILLEGAL_TRAP_EN is undefined, treat an illegal opcode as NOP: DECODE->FETCH, with no register or memory write; ERR SHALL be unreachable.

Verification
REQ-033 SHALL cover: opcode=0110011, funct3=000, funct7=0100000 -> states 1,2,3,5,1; ALU_OP=1000 in EXE_R; Reg_Write=1 only in WB.
REQ-034 SHALL cover: opcode=0000011 -> states 1,2,7,8,9,1; w_data_s=10 and Reg_Write=1 in LOAD_WB; Mem_Write is never 1.
REQ-035 SHALL cover: opcode=1100011, funct3=000, with ZF=1 then ZF=0 -> PC_Write=1 and PC_s=01 in BEQ for the first case; PC_Write=0 in BEQ for the second.
REQ-036 SHALL cover: opcode=0010011, funct3=101, funct7=0100000 -> ALU_OP=1101 and rs2_imm_s=1 in EXE_I.
REQ-037 SHALL cover: opcode=1111111 -> state 15 held for at least 10 cycles with the macro defined; return to FETCH with no writes without it.
REQ-038 SHALL cover: rst_n pulsed low during LOAD_WB -> Reg_Write drops to 0 asynchronously; state_dbg=0, then 1 on the first edge after release.

Source files
------------

// File: rtl/instr_ctrl_if.sv
// Decoder-to-controller bundle for instr_ctrl_fsm: decoder fields and flag in,
// datapath enables, selects, ALU opcode and state debug out.
interface instr_ctrl_if;
  // Protocol: there is no valid/ready pair. The controller samples opcode,
  // funct3, funct7 and ZF combinationally every cycle. The decoder holds them
  // stable from FETCH until the next FETCH. ZF is already registered by the
  // ALU stage and must be settled in the BEQ cycle.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ZF;

  logic       PC_Write;
  logic       IR_Write;
  logic       PC0_Write;
  logic       Reg_Write;
  logic       Mem_Write;
  logic       rs2_imm_s;
  logic [1:0] w_data_s;
  logic [1:0] PC_s;
  logic [3:0] ALU_OP;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct3, funct7, ZF,
    output PC_Write, IR_Write, PC0_Write, Reg_Write, Mem_Write,
    output rs2_imm_s, w_data_s, PC_s, ALU_OP, state_dbg
  );

  modport slave (
    output opcode, funct3, funct7, ZF,
    input  PC_Write, IR_Write, PC0_Write, Reg_Write, Mem_Write,
    input  rs2_imm_s, w_data_s, PC_s, ALU_OP, state_dbg
  );
endinterface

// File: rtl/instr_ctrl_fsm.sv
// Multi-cycle Moore controller for the RV32 subset (R/I ALU, LUI, LW, SW, BEQ, JAL).
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes in ERR; otherwise they run as NOPs.
module instr_ctrl_fsm (
  input  logic clk,
  input  logic rst_n,
  instr_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXE_R    = 4'd3,
    S_EXE_I    = 4'd4,
    S_WB       = 4'd5,
    S_LUI      = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_LOAD     = 4'd8,
    S_LOAD_WB  = 4'd9,
    S_STORE    = 4'd10,
    S_BEQ      = 4'd11,
    S_JAL      = 4'd12,
    S_ERR      = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_IMM = 2'b01;
  localparam logic [1:0] WD_MEM = 2'b10;
  localparam logic [1:0] WD_PC  = 2'b11;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_REL = 2'b01;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NXT = S_ERR;
`else
  localparam state_t ILLEGAL_NXT = S_FETCH;
`endif

  state_t state;
  state_t state_nxt;
  state_t decode_nxt;

  logic       pc_write;
  logic       ir_write;
  logic       pc0_write;
  logic       reg_write;
  logic       mem_write;
  logic       rs2_imm_s;
  logic [1:0] w_data_s;
  logic [1:0] pc_s;
  logic [3:0] alu_op;

  logic       is_srai_srli;
  logic       unused_funct7;

  // Only funct7[5] carries meaning (SUB/SRA); the rest of the field is ignored.
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};
  assign is_srai_srli  = (bus.funct3 == 3'b101);

  // State register; the async reset also zeroes every output, since IDLE drives nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Opcode dispatch out of DECODE.
  always_comb begin
    decode_nxt = ILLEGAL_NXT;
    case (bus.opcode)
      OP_R:      decode_nxt = S_EXE_R;
      OP_I:      decode_nxt = S_EXE_I;
      OP_LUI:    decode_nxt = S_LUI;
      OP_LOAD:   decode_nxt = S_MEM_ADDR;
      OP_STORE:  decode_nxt = S_MEM_ADDR;
      OP_BRANCH: decode_nxt = (bus.funct3 == 3'b000) ? S_BEQ : ILLEGAL_NXT;
      OP_JAL:    decode_nxt = S_JAL;
      default:   decode_nxt = ILLEGAL_NXT;
    endcase
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:     state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_DECODE;
      S_DECODE:   state_nxt = decode_nxt;
      S_EXE_R:    state_nxt = S_WB;
      S_EXE_I:    state_nxt = S_WB;
      S_WB:       state_nxt = S_FETCH;
      S_LUI:      state_nxt = S_FETCH;
      S_MEM_ADDR: state_nxt = (bus.opcode == OP_LOAD) ? S_LOAD : S_STORE;
      S_LOAD:     state_nxt = S_LOAD_WB;
      S_LOAD_WB:  state_nxt = S_FETCH;
      S_STORE:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ERR:      state_nxt = S_ERR;
`endif
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output decode: each write enable is owned by exactly one group of states,
  // so Reg_Write, Mem_Write and IR_Write can never overlap.
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    pc0_write = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    rs2_imm_s = 1'b0;
    w_data_s  = WD_ALU;
    pc_s      = PCS_SEQ;
    alu_op    = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        pc0_write = 1'b1;
        pc_s      = PCS_SEQ;
      end
      S_EXE_R: begin
        alu_op    = {bus.funct7[5], bus.funct3};
        rs2_imm_s = 1'b0;
      end
      S_EXE_I: begin
        // Only shift-right immediates use funct7[5]; ADDI etc. leave it as imm bits.
        alu_op    = {bus.funct7[5] & is_srai_srli, bus.funct3};
        rs2_imm_s = 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        w_data_s  = WD_ALU;
      end
      S_LUI: begin
        reg_write = 1'b1;
        w_data_s  = WD_IMM;
      end
      S_MEM_ADDR: begin
        alu_op    = ALU_ADD;
        rs2_imm_s = 1'b1;
      end
      S_LOAD_WB: begin
        reg_write = 1'b1;
        w_data_s  = WD_MEM;
      end
      S_STORE: begin
        mem_write = 1'b1;
      end
      S_BEQ: begin
        alu_op    = ALU_SUB;
        rs2_imm_s = 1'b0;
        if (bus.ZF) begin
          pc_write = 1'b1;
          pc_s     = PCS_REL;
        end
      end
      S_JAL: begin
        reg_write = 1'b1;
        w_data_s  = WD_PC;
        pc_write  = 1'b1;
        pc_s      = PCS_REL;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign bus.PC_Write  = pc_write;
  assign bus.IR_Write  = ir_write;
  assign bus.PC0_Write = pc0_write;
  assign bus.Reg_Write = reg_write;
  assign bus.Mem_Write = mem_write;
  assign bus.rs2_imm_s = rs2_imm_s;
  assign bus.w_data_s  = w_data_s;
  assign bus.PC_s      = pc_s;
  assign bus.ALU_OP    = alu_op;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Bench for instr_ctrl_fsm: per-cycle expected state/output vectors are queued
// by the driver and popped by a negedge monitor. Honors CTRL_ILLEGAL_TRAP_EN.
module tb_instr_ctrl_fsm;

  logic clk;
  logic rst_n;

  instr_ctrl_if bus ();

  instr_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Vector layout: {state[3:0], PC_Write, IR_Write, PC0_Write, Reg_Write,
  //                 Mem_Write, rs2_imm_s, w_data_s[1:0], PC_s[1:0], ALU_OP[3:0]}
  logic [17:0] exp_q[$];
  string       name_q[$];

  int n_checks;
  int n_fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] exp_v(input logic [3:0] st, input logic pcw,
                                        input logic irw, input logic pc0w,
                                        input logic rw, input logic mw,
                                        input logic rs2, input logic [1:0] wds,
                                        input logic [1:0] pcs, input logic [3:0] alu);
    return {st, pcw, irw, pc0w, rw, mw, rs2, wds, pcs, alu};
  endfunction

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare whatever the DUT presents this cycle against the queue head.
  logic [17:0] act_vec;
  logic [17:0] head;
  string       head_name;
  always @(negedge clk) begin
    act_vec = {bus.state_dbg, bus.PC_Write, bus.IR_Write, bus.PC0_Write,
               bus.Reg_Write, bus.Mem_Write, bus.rs2_imm_s, bus.w_data_s,
               bus.PC_s, bus.ALU_OP};
    if (exp_q.size() > 0) begin
      head      = exp_q.pop_front();
      head_name = name_q.pop_front();
      chk(head_name, act_vec, head);
      chk("write_exclusive",
          18'(int'(bus.Reg_Write) + int'(bus.Mem_Write) + int'(bus.IR_Write) > 1),
          18'd0);
    end
  end

  // Driver: queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string name, input logic [17:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic zf);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.ZF     = zf;
  endtask

  logic [17:0] v_idle, v_fetch, v_dec;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    v_idle   = exp_v(4'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000);
    v_fetch  = exp_v(4'd1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000);
    v_dec    = exp_v(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000);

    rst_n = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0, 1'b0);
    @(posedge clk);
    #1;
    cyc("reset_idle0", v_idle);
    cyc("reset_idle1", v_idle);
    rst_n = 1'b1;
    cyc("release_idle", v_idle);

    // SUB: 1,2,3,5
    set_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0);
    cyc("sub_fetch", v_fetch);
    cyc("sub_decode", v_dec);
    cyc("sub_exe_r", exp_v(4'd3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b1000));
    cyc("sub_wb",    exp_v(4'd5, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000));

    // AND (funct7=0, funct3=111)
    set_instr(7'b0110011, 3'b111, 7'b0000000, 1'b0);
    cyc("and_fetch", v_fetch);
    cyc("and_decode", v_dec);
    cyc("and_exe_r", exp_v(4'd3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0111));
    cyc("and_wb",    exp_v(4'd5, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000));

    // SRAI
    set_instr(7'b0010011, 3'b101, 7'b0100000, 1'b0);
    cyc("srai_fetch", v_fetch);
    cyc("srai_decode", v_dec);
    cyc("srai_exe_i", exp_v(4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b1101));
    cyc("srai_wb",    exp_v(4'd5, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000));

    // ADDI with imm bit 10 set: must not become a subtract
    set_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0);
    cyc("addi_fetch", v_fetch);
    cyc("addi_decode", v_dec);
    cyc("addi_exe_i", exp_v(4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000));
    cyc("addi_wb",    exp_v(4'd5, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000));

    // LUI: 3 cycles
    set_instr(7'b0110111, 3'b000, 7'b0000000, 1'b0);
    cyc("lui_fetch", v_fetch);
    cyc("lui_decode", v_dec);
    cyc("lui_wr", exp_v(4'd6, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 4'b0000));

    // SW: 4 cycles
    set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    cyc("sw_fetch", v_fetch);
    cyc("sw_decode", v_dec);
    cyc("sw_addr",  exp_v(4'd7, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000));
    cyc("sw_store", exp_v(4'd10, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000));

    // BEQ taken
    set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1);
    cyc("beq_t_fetch", v_fetch);
    cyc("beq_t_decode", v_dec);
    cyc("beq_taken", exp_v(4'd11, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'b1000));

    // BEQ not taken
    set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0);
    cyc("beq_n_fetch", v_fetch);
    cyc("beq_n_decode", v_dec);
    cyc("beq_not_taken", exp_v(4'd11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b1000));

    // JAL
    set_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0);
    cyc("jal_fetch", v_fetch);
    cyc("jal_decode", v_dec);
    cyc("jal_exec", exp_v(4'd12, 1, 0, 0, 1, 0, 0, 2'b11, 2'b01, 4'b0000));

    // LW: 5 cycles
    set_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    cyc("lw_fetch", v_fetch);
    cyc("lw_decode", v_dec);
    cyc("lw_addr",  exp_v(4'd7, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000));
    cyc("lw_load",  exp_v(4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000));
    cyc("lw_wb",    exp_v(4'd9, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 4'b0000));

    // LW again, reset pulsed in the middle of LOAD_WB
    cyc("lw2_fetch", v_fetch);
    cyc("lw2_decode", v_dec);
    cyc("lw2_addr", exp_v(4'd7, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000));
    cyc("lw2_load", exp_v(4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000));
    chk("lw2_wb_regw_pre", 18'(bus.Reg_Write), 18'd1);
    chk("lw2_wb_state_pre", 18'(bus.state_dbg), 18'd9);
    rst_n = 1'b0;
    #1;
    chk("async_rst_regw", 18'(bus.Reg_Write), 18'd0);
    chk("async_rst_state", 18'(bus.state_dbg), 18'd0);
    chk("async_rst_wds", 18'(bus.w_data_s), 18'd0);
    @(posedge clk);
    #1;
    cyc("rst_hold_idle", v_idle);
    rst_n = 1'b1;
    cyc("rst_release_idle", v_idle);

    // Illegal opcode
    set_instr(7'b1111111, 3'b000, 7'b0000000, 1'b0);
    cyc("ill_fetch", v_fetch);
    cyc("ill_decode", v_dec);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 12; i++) begin
      cyc("ill_err_hold", exp_v(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000));
    end
    rst_n = 1'b0;
    #1;
    chk("err_async_rst_state", 18'(bus.state_dbg), 18'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("err_rst_idle", v_idle);
    set_instr(7'b0110111, 3'b000, 7'b0000000, 1'b0);
    cyc("post_err_fetch", v_fetch);
`else
    // BEQ encoding with funct3!=000 is also illegal
    set_instr(7'b1100011, 3'b001, 7'b0000000, 1'b1);
    cyc("ill_nop_fetch", v_fetch);
    cyc("bne_decode", v_dec);
    set_instr(7'b0110111, 3'b000, 7'b0000000, 1'b0);
    cyc("bne_nop_fetch", v_fetch);
`endif
    cyc("final_decode", v_dec);

    @(negedge clk);
    #1;
    chk("queue_drained", 18'(exp_q.size()), 18'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
